// File: rtl/raw_video_decoder.sv
// Raw composite video decoder: qualifies hsync, locks a 12-phase counter to the
// colour burst and recovers hue/luma/tint from 8-sample pixel windows.
module raw_video_decoder #(
    parameter int unsigned SYNC_MIN   = 64,
    parameter int unsigned ACTIVE_OFS = 296,
    parameter int unsigned PIXELS     = 256
) (
    input  logic        CLK,
    input  logic        n_RES,
    input  logic [10:0] RawVOut,
    output logic        pix_valid,
    output logic [3:0]  pix_hue,
    output logic [1:0]  pix_luma,
    output logic        pix_tint,
    output logic [8:0]  pix_x,
    output logic        pix_err,
    output logic        line_start,
    output logic        locked,
    output logic        line_err
);

    localparam int unsigned RUN_W = $clog2(SYNC_MIN + 1);
    localparam int unsigned OFS_W = $clog2(ACTIVE_OFS + 1);
    localparam int unsigned X_W   = 9;
    localparam int unsigned LVL_W = 4;
    localparam int unsigned PH_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_BACKPORCH, S_ACTIVE} state_e;

    state_e             state_q, state_d;
    logic [10:0]        w_q;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [OFS_W-1:0]   ofs_q, ofs_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [PH_W-1:0]    ph0_q, ph0_d;
    logic [LVL_W-1:0]   lvl_prev_q;
    logic               locked_q, locked_d;
    logic [2:0]         win_q, win_d;
    logic               tint_q, tint_d;
    logic [LVL_W-1:0]   lv_q [8];
    logic               lv_we;

    logic               pix_valid_q, pix_valid_d;
    logic [3:0]         pix_hue_q, pix_hue_d;
    logic [1:0]         pix_luma_q, pix_luma_d;
    logic               pix_tint_q, pix_tint_d;
    logic [X_W-1:0]     pix_x_q, pix_x_d;
    logic               pix_err_q, pix_err_d;
    logic               line_start_q, line_start_d;
    logic               line_err_q, line_err_d;

    logic [LVL_W-1:0]   lvl_c;
    logic               sync_c;
    logic [LVL_W-1:0]   lv_all [8];
    logic [LVL_W-1:0]   lo_c, hi_c;
    logic               rise_c, fall_c;
    logic [PH_W-1:0]    r_rise_c, r_fall_c, r_c;
    logic [3:0]         dec_hue_c;
    logic [1:0]         dec_luma_c;
    logic               dec_err_c;
    logic               tint_win_c;
    logic               burst_step_c;

    function automatic logic [LVL_W-1:0] level_of(input logic [8:0] taps);
        logic [LVL_W-1:0] l;
        l = '0;
        for (int i = 0; i < 9; i++) begin
            if (taps[i]) l = LVL_W'(i + 1);
        end
        return l;
    endfunction

    function automatic logic [PH_W-1:0] add_mod12(input logic [PH_W-1:0] a, input logic [PH_W-1:0] b);
        logic [PH_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd12) s = s - 5'd12;
        return s[PH_W-1:0];
    endfunction

    assign lvl_c  = level_of(w_q[9:1]);
    assign sync_c = w_q[0];
    assign burst_step_c = (state_q == S_BACKPORCH) && !sync_c && !locked_q
                          && (lvl_prev_q == 4'd1) && (lvl_c == 4'd4);

    // Window classification; only meaningful on the 8th sample of a window.
    always_comb begin
        for (int i = 0; i < 7; i++) lv_all[i] = lv_q[i];
        lv_all[7] = lvl_c;
        lo_c = lv_all[0];
        hi_c = lv_all[0];
        for (int i = 1; i < 8; i++) begin
            if (lv_all[i] < lo_c) lo_c = lv_all[i];
            if (lv_all[i] > hi_c) hi_c = lv_all[i];
        end
        rise_c   = 1'b0;
        fall_c   = 1'b0;
        r_rise_c = '0;
        r_fall_c = '0;
        for (int i = 1; i < 8; i++) begin
            if (!rise_c && lv_all[i] == hi_c && lv_all[i-1] != hi_c) begin
                rise_c   = 1'b1;
                r_rise_c = add_mod12(ph0_q, PH_W'(i));
            end
            if (!fall_c && lv_all[i] != hi_c && lv_all[i-1] == hi_c) begin
                fall_c   = 1'b1;
                r_fall_c = add_mod12(ph0_q, PH_W'(i));
            end
        end
        r_c        = rise_c ? r_rise_c : add_mod12(r_fall_c, 4'd6);
        dec_err_c  = 1'b0;
        dec_hue_c  = '0;
        dec_luma_c = '0;
        if (hi_c == lo_c) begin
            case (hi_c)
                4'd6:    begin dec_hue_c = 4'h0; dec_luma_c = 2'd0; end
                4'd7:    begin dec_hue_c = 4'h0; dec_luma_c = 2'd1; end
                4'd9:    begin dec_hue_c = 4'h0; dec_luma_c = 2'd3; end
                4'd2:    begin dec_hue_c = 4'hD; dec_luma_c = 2'd0; end
                4'd5:    begin dec_hue_c = 4'hD; dec_luma_c = 2'd2; end
                4'd8:    begin dec_hue_c = 4'hD; dec_luma_c = 2'd3; end
                4'd3:    begin dec_hue_c = 4'hF; dec_luma_c = 2'd0; end
                default: dec_err_c = 1'b1;
            endcase
        end else begin
            if (lo_c == 4'd2 && hi_c == 4'd6)      dec_luma_c = 2'd0;
            else if (lo_c == 4'd3 && hi_c == 4'd7) dec_luma_c = 2'd1;
            else if (lo_c == 4'd5 && hi_c == 4'd9) dec_luma_c = 2'd2;
            else if (lo_c == 4'd8 && hi_c == 4'd9) dec_luma_c = 2'd3;
            else                                   dec_err_c  = 1'b1;
            if (!rise_c && !fall_c) dec_err_c = 1'b1;
            dec_hue_c = add_mod12(r_c, 4'd7) + 4'd1;
        end
        if (!locked_q) dec_err_c = 1'b1;
        tint_win_c = ((win_q == 3'd0) ? 1'b0 : tint_q) | w_q[10];
    end

    always_ff @(posedge CLK) begin
        if (!n_RES) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (sync_c && run_q >= RUN_W'(SYNC_MIN - 1)) state_d = S_SYNC;
            S_SYNC:      if (!sync_c) state_d = S_BACKPORCH;
            S_BACKPORCH: begin
                if (sync_c)                                   state_d = S_IDLE;
                else if (ofs_q == OFS_W'(ACTIVE_OFS - 1))     state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (sync_c)                                           state_d = S_IDLE;
                else if (win_q == 3'd7 && pix_x_q == X_W'(PIXELS - 1)) state_d = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Counters, burst capture and registered pixel results.
    always_comb begin
        run_d        = sync_c ? ((run_q == RUN_W'(SYNC_MIN)) ? run_q : run_q + RUN_W'(1)) : '0;
        ph_d         = add_mod12(ph_q, 4'd1);
        ofs_d        = ofs_q;
        locked_d     = locked_q;
        win_d        = '0;
        ph0_d        = ph0_q;
        tint_d       = tint_q;
        lv_we        = 1'b0;
        pix_valid_d  = 1'b0;
        pix_hue_d    = pix_hue_q;
        pix_luma_d   = pix_luma_q;
        pix_tint_d   = pix_tint_q;
        pix_err_d    = pix_err_q;
        pix_x_d      = pix_valid_q ? pix_x_q + X_W'(1) : pix_x_q;
        line_start_d = 1'b0;
        line_err_d   = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (!sync_c) begin
                    line_start_d = 1'b1;
                    locked_d     = 1'b0;
                    ofs_d        = OFS_W'(1);
                    pix_x_d      = '0;
                end
            end
            S_BACKPORCH: begin
                if (!sync_c) ofs_d = ofs_q + OFS_W'(1);
                if (burst_step_c) begin
                    locked_d = 1'b1;
                    ph_d     = 4'd1;
                end
            end
            S_ACTIVE: begin
                if (sync_c) begin
                    line_err_d = 1'b1;
                end else begin
                    win_d  = win_q + 3'd1;
                    lv_we  = 1'b1;
                    tint_d = tint_win_c;
                    if (win_q == 3'd0) ph0_d = ph_q;
                    if (win_q == 3'd7) begin
                        pix_valid_d = 1'b1;
                        pix_hue_d   = dec_hue_c;
                        pix_luma_d  = dec_luma_c;
                        pix_tint_d  = tint_win_c;
                        pix_err_d   = dec_err_c;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            w_q          <= '0;
            run_q        <= '0;
            ofs_q        <= '0;
            ph_q         <= '0;
            ph0_q        <= '0;
            lvl_prev_q   <= '0;
            locked_q     <= 1'b0;
            win_q        <= '0;
            tint_q       <= 1'b0;
            for (int i = 0; i < 8; i++) lv_q[i] <= '0;
            pix_valid_q  <= 1'b0;
            pix_hue_q    <= '0;
            pix_luma_q   <= '0;
            pix_tint_q   <= 1'b0;
            pix_x_q      <= '0;
            pix_err_q    <= 1'b0;
            line_start_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            w_q          <= RawVOut;
            run_q        <= run_d;
            ofs_q        <= ofs_d;
            ph_q         <= ph_d;
            ph0_q        <= ph0_d;
            lvl_prev_q   <= lvl_c;
            locked_q     <= locked_d;
            win_q        <= win_d;
            tint_q       <= tint_d;
            if (lv_we) lv_q[win_q] <= lvl_c;
            pix_valid_q  <= pix_valid_d;
            pix_hue_q    <= pix_hue_d;
            pix_luma_q   <= pix_luma_d;
            pix_tint_q   <= pix_tint_d;
            pix_x_q      <= pix_x_d;
            pix_err_q    <= pix_err_d;
            line_start_q <= line_start_d;
            line_err_q   <= line_err_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_hue    = pix_hue_q;
    assign pix_luma   = pix_luma_q;
    assign pix_tint   = pix_tint_q;
    assign pix_x      = pix_x_q;
    assign pix_err    = pix_err_q;
    assign line_start = line_start_q;
    assign locked     = locked_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_raw_video_decoder.sv
// Directed bench for raw_video_decoder: drives whole lines (sync, porch with
// optional burst, pixel samples) and checks every decoded pixel against constants.
`timescale 1ns/1ps
module tb_raw_video_decoder;

    typedef struct packed {
        logic [3:0] hue;
        logic [1:0] luma;
        logic       tint;
        logic [8:0] x;
        logic       err;
    } rec_t;

    logic        CLK;
    logic        n_RES;
    logic [10:0] RawVOut;
    logic        pix_valid;
    logic [3:0]  pix_hue;
    logic [1:0]  pix_luma;
    logic        pix_tint;
    logic [8:0]  pix_x;
    logic        pix_err;
    logic        line_start;
    logic        locked;
    logic        line_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_ls = 0;
    int   n_le = 0;
    int   valid_cyc = -1;
    int   mark_cyc = 0;
    rec_t recs[$];

    raw_video_decoder dut (
        .CLK        (CLK),
        .n_RES      (n_RES),
        .RawVOut    (RawVOut),
        .pix_valid  (pix_valid),
        .pix_hue    (pix_hue),
        .pix_luma   (pix_luma),
        .pix_tint   (pix_tint),
        .pix_x      (pix_x),
        .pix_err    (pix_err),
        .line_start (line_start),
        .locked     (locked),
        .line_err   (line_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (pix_valid === 1'b1) begin
            recs.push_back({pix_hue, pix_luma, pix_tint, pix_x, pix_err});
            if (valid_cyc < 0) valid_cyc = cyc;
        end
        if (line_start === 1'b1) n_ls++;
        if (line_err === 1'b1) n_le++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] lw(input int lvl, input bit tint);
        logic [10:0] v;
        v = '0;
        if (lvl > 0) v[lvl] = 1'b1;
        v[10] = tint;
        return v;
    endfunction

    task automatic drive(input logic [10:0] wv);
        @(negedge CLK);
        RawVOut = wv;
    endtask

    task automatic clear_mon();
        recs.delete();
        n_ls = 0;
        n_le = 0;
        valid_cyc = -1;
    endtask

    task automatic send_sync(input int n);
        repeat (n) drive(11'h001);
    endtask

    // Blanking at level 1 with a 1/4 burst at offsets 20..139 (phase 0 at offset 20).
    task automatic send_porch(input bit burst);
        int lv;
        for (int o = 0; o < 296; o++) begin
            lv = 1;
            if (burst && o >= 20 && o < 140) lv = (((o - 20) % 12) < 6) ? 4 : 1;
            drive(lw(lv, 1'b0));
        end
    endtask

    // 12-sample square wave, high at hi for phases d..d+5, else lo.
    task automatic send_pix(input int lo, input int hi, input int d, input int tint_t,
                            input int first, input int npix);
        int p;
        int lv;
        for (int t = first * 8; t < (first + npix) * 8; t++) begin
            p  = (((t - d) % 12) + 12) % 12;
            lv = (p < 6) ? hi : lo;
            drive(lw(lv, t == tint_t));
            if (t == 7) mark_cyc = cyc;
        end
    endtask

    task automatic send_line(input bit burst, input int lo, input int hi, input int d,
                             input int tint_t);
        send_sync(64);
        send_porch(burst);
        send_pix(lo, hi, d, tint_t, 0, 256);
        repeat (20) drive(lw(1, 1'b0));
    endtask

    task automatic test_reset();
        logic [20:0] outs;
        n_RES = 1'b0;
        RawVOut = '0;
        repeat (3) @(negedge CLK);
        outs = {pix_valid, pix_hue, pix_luma, pix_tint, pix_x, pix_err, line_start, locked, line_err};
        checks++;
        if (outs !== 21'd0) begin
            errors++;
            $display("FAIL reset_init: got %h want 0", outs);
        end
        n_RES = 1'b1;
        clear_mon();
        send_sync(64);
        send_porch(1'b1);
        send_pix(7, 7, 0, -1, 0, 20);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_locked: got %b want 1", locked);
        end
        repeat (3) begin
            @(negedge CLK);
            n_RES = 1'b0;
            RawVOut = lw(7, 1'b0);
        end
        @(negedge CLK);
        outs = {pix_valid, pix_hue, pix_luma, pix_tint, pix_x, pix_err, line_start, locked, line_err};
        checks++;
        if (outs !== 21'd0) begin
            errors++;
            $display("FAIL reset_midline: got %h want 0", outs);
        end
        n_RES = 1'b1;
        RawVOut = lw(7, 1'b0);
        clear_mon();
        send_pix(7, 7, 0, -1, 24, 100);
        repeat (10) drive(lw(1, 1'b0));
        checks++;
        if (recs.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_valid: got %0d want 0", recs.size());
        end
        checks++;
        if (n_ls !== 0) begin
            errors++;
            $display("FAIL reset_no_line_start: got %0d want 0", n_ls);
        end
    endtask

    task automatic test_const_line();
        rec_t exp;
        clear_mon();
        send_line(1'b1, 7, 7, 0, -1);
        checks++;
        if (n_ls !== 1) begin
            errors++;
            $display("FAIL const7_line_start: got %0d want 1", n_ls);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL const7_locked: got %b want 1", locked);
        end
        checks++;
        if (recs.size() !== 256) begin
            errors++;
            $display("FAIL const7_count: got %0d want 256", recs.size());
        end
        checks++;
        if (valid_cyc - mark_cyc !== 2) begin
            errors++;
            $display("FAIL const7_latency: got %0d want 2", valid_cyc - mark_cyc);
        end
        for (int i = 0; i < recs.size(); i++) begin
            exp = {4'h0, 2'd1, 1'b0, 9'(i), 1'b0};
            checks++;
            if (recs[i] !== exp) begin
                errors++;
                $display("FAIL const7_pix[%0d]: got %h want %h", i, recs[i], exp);
            end
        end
    endtask

    task automatic test_hue_phase();
        int         dly [3];
        logic [3:0] eh  [3];
        rec_t       exp;
        dly = '{0, 3, 9};
        eh  = '{4'd8, 4'd11, 4'd5};
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            send_line(1'b1, 3, 7, dly[k], -1);
            checks++;
            if (recs.size() !== 256) begin
                errors++;
                $display("FAIL hue_d%0d_count: got %0d want 256", dly[k], recs.size());
            end
            for (int i = 0; i < recs.size(); i++) begin
                exp = {eh[k], 2'd1, 1'b0, 9'(i), 1'b0};
                checks++;
                if (recs[i] !== exp) begin
                    errors++;
                    $display("FAIL hue_d%0d_pix[%0d]: got %h want %h", dly[k], i, recs[i], exp);
                end
            end
        end
    endtask

    task automatic test_const_levels();
        int         lvl [6];
        logic [3:0] eh  [6];
        logic [1:0] el  [6];
        rec_t       exp;
        lvl = '{3, 5, 8, 9, 2, 6};
        eh  = '{4'hF, 4'hD, 4'hD, 4'h0, 4'hD, 4'h0};
        el  = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        for (int k = 0; k < 6; k++) begin
            clear_mon();
            send_line(1'b1, lvl[k], lvl[k], 0, (k == 0) ? 43 : -1);
            checks++;
            if (recs.size() !== 256) begin
                errors++;
                $display("FAIL lvl%0d_count: got %0d want 256", lvl[k], recs.size());
            end
            for (int i = 0; i < recs.size(); i++) begin
                exp = {eh[k], el[k], (k == 0 && i == 5), 9'(i), 1'b0};
                checks++;
                if (recs[i] !== exp) begin
                    errors++;
                    $display("FAIL lvl%0d_pix[%0d]: got %h want %h", lvl[k], i, recs[i], exp);
                end
            end
        end
        clear_mon();
        send_line(1'b1, 4, 6, 0, -1);
        checks++;
        if (recs.size() !== 256) begin
            errors++;
            $display("FAIL pair46_count: got %0d want 256", recs.size());
        end
        for (int i = 0; i < recs.size(); i++) begin
            checks++;
            if (recs[i].err !== 1'b1) begin
                errors++;
                $display("FAIL pair46_err[%0d]: got %b want 1", i, recs[i].err);
            end
        end
    endtask

    task automatic test_no_burst();
        clear_mon();
        send_line(1'b0, 7, 7, 0, -1);
        checks++;
        if (n_ls !== 1) begin
            errors++;
            $display("FAIL noburst_line_start: got %0d want 1", n_ls);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL noburst_locked: got %b want 0", locked);
        end
        checks++;
        if (recs.size() !== 256) begin
            errors++;
            $display("FAIL noburst_count: got %0d want 256", recs.size());
        end
        for (int i = 0; i < recs.size(); i++) begin
            checks++;
            if (recs[i].err !== 1'b1) begin
                errors++;
                $display("FAIL noburst_err[%0d]: got %b want 1", i, recs[i].err);
            end
        end
        clear_mon();
        send_sync(63);
        repeat (400) drive(lw(1, 1'b0));
        checks++;
        if (n_ls !== 0) begin
            errors++;
            $display("FAIL sync63_line_start: got %0d want 0", n_ls);
        end
        checks++;
        if (recs.size() !== 0) begin
            errors++;
            $display("FAIL sync63_valid: got %0d want 0", recs.size());
        end
    endtask

    task automatic test_line_err();
        rec_t exp;
        clear_mon();
        send_sync(64);
        send_porch(1'b1);
        send_pix(7, 7, 0, -1, 0, 100);
        send_sync(10);
        checks++;
        if (n_le !== 1) begin
            errors++;
            $display("FAIL abort_line_err: got %0d want 1", n_le);
        end
        checks++;
        if (recs.size() !== 100) begin
            errors++;
            $display("FAIL abort_count: got %0d want 100", recs.size());
        end
        for (int i = 0; i < recs.size(); i++) begin
            exp = {4'h0, 2'd1, 1'b0, 9'(i), 1'b0};
            checks++;
            if (recs[i] !== exp) begin
                errors++;
                $display("FAIL abort_pix[%0d]: got %h want %h", i, recs[i], exp);
            end
        end
        clear_mon();
        send_sync(54);
        send_porch(1'b1);
        send_pix(7, 7, 0, -1, 0, 256);
        repeat (20) drive(lw(1, 1'b0));
        checks++;
        if (n_ls !== 1) begin
            errors++;
            $display("FAIL after_abort_line_start: got %0d want 1", n_ls);
        end
        checks++;
        if (n_le !== 0) begin
            errors++;
            $display("FAIL after_abort_line_err: got %0d want 0", n_le);
        end
        checks++;
        if (recs.size() !== 256) begin
            errors++;
            $display("FAIL after_abort_count: got %0d want 256", recs.size());
        end
        for (int i = 0; i < recs.size(); i++) begin
            exp = {4'h0, 2'd1, 1'b0, 9'(i), 1'b0};
            checks++;
            if (recs[i] !== exp) begin
                errors++;
                $display("FAIL after_abort_pix[%0d]: got %h want %h", i, recs[i], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_line();
        test_hue_phase();
        test_const_levels();
        test_no_burst();
        test_line_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
